// File: rtl/l2_cache_pkg.sv
// l2_cache_pkg: shared types and geometry helpers for the L2 cache controller.
//   l2_state_e   controller FSM state encoding
//   *_w()        address-field widths derived from the cache parameters
//   line_t       cache line type for the default geometry (4 x 32-bit words)
package l2_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_WRITE_BACK,
    ST_ALLOCATE,
    ST_RESPOND
  } l2_state_e;

  function automatic int byte_off_w(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int word_off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int addr_width, input int data_width,
                               input int words_per_line, input int num_sets);
    return addr_width - byte_off_w(data_width) - word_off_w(words_per_line)
           - index_w(num_sets);
  endfunction

  localparam int DEF_LINE_W = 32 * 4;
  typedef logic [DEF_LINE_W-1:0] line_t;

endpackage

// File: rtl/l2_cache_ctrl_lru.sv
// l2_lru_set: true-LRU age update and victim pick for one set.
//   age_i      current per-way ages (0 = MRU, NUM_WAYS-1 = LRU)
//   acc_way_i  way being accessed
//   age_o      ages after accessing acc_way_i
//   lru_way_o  way currently holding the oldest age
module l2_lru_set #(
  parameter int NUM_WAYS = 4,
  parameter int AGE_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0][AGE_W-1:0] age_i,
  input  logic [AGE_W-1:0]               acc_way_i,
  output logic [NUM_WAYS-1:0][AGE_W-1:0] age_o,
  output logic [AGE_W-1:0]               lru_way_o
);

  logic [AGE_W-1:0] acc_age;

  // Ages always form a permutation of 0..NUM_WAYS-1, so exactly one way
  // matches the maximum age.
  always_comb begin
    acc_age   = age_i[acc_way_i];
    age_o     = age_i;
    lru_way_o = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (age_i[w] < acc_age) age_o[w] = age_i[w] + AGE_W'(1);
      if (age_i[w] == AGE_W'(NUM_WAYS - 1)) lru_way_o = AGE_W'(w);
    end
    age_o[acc_way_i] = '0;
  end

endmodule

// File: rtl/l2_cache_ctrl.sv
// l2_cache_ctrl: N-way set-associative, write-back, write-allocate L2 cache
// controller with true-LRU replacement and saturating hit/miss statistics.
//   clk, reset_n                 clock, async active-low reset
//   req_*  / resp_*              L1-side word request / one-cycle response
//   mem_req_* / mem_resp_*       L3-side line write-back / line fill
//   hit_count, miss_count        saturating statistics
//
// state       | meaning
// ------------+-------------------------------------------------------
// IDLE        | ready for an L1 request
// COMPARE     | tag lookup in the indexed set; hit completes, miss picks victim
// WRITE_BACK  | sending dirty victim line to L3
// ALLOCATE    | requesting fill from L3, then waiting for the fill line
// RESPOND     | one-cycle response to L1
module l2_cache_ctrl
  import l2_cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_SETS       = 16,
  parameter int NUM_WAYS       = 4
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_write,
  input  logic [ADDR_WIDTH-1:0]                req_addr,
  input  logic [DATA_WIDTH-1:0]                req_wdata,
  output logic                                 resp_valid,
  output logic [DATA_WIDTH-1:0]                resp_rdata,
  output logic                                 resp_hit,
  output logic                                 mem_req_valid,
  input  logic                                 mem_req_ready,
  output logic                                 mem_req_write,
  output logic [ADDR_WIDTH-1:0]                mem_req_addr,
  output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] mem_req_wdata,
  input  logic                                 mem_resp_valid,
  input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] mem_resp_rdata,
  output logic [31:0]                          hit_count,
  output logic [31:0]                          miss_count
);

  localparam int BYTE_W  = byte_off_w(DATA_WIDTH);
  localparam int WORD_W  = word_off_w(WORDS_PER_LINE);
  localparam int INDEX_W = index_w(NUM_SETS);
  localparam int TAG_W   = tag_w(ADDR_WIDTH, DATA_WIDTH, WORDS_PER_LINE, NUM_SETS);
  localparam int OFF_W   = BYTE_W + WORD_W;
  localparam int WAY_W   = $clog2(NUM_WAYS);
  localparam int LINE_W  = DATA_WIDTH * WORDS_PER_LINE;

  l2_state_e state_q, state_d;
  logic                  ready_en_q, ready_en_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  first_q, first_d;
  logic                  fill_wait_q, fill_wait_d;
  logic [WAY_W-1:0]      victim_q, victim_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  hit_q, hit_d;
  logic [31:0]           hit_cnt_q, hit_cnt_d;
  logic [31:0]           miss_cnt_q, miss_cnt_d;

  logic [NUM_SETS-1:0][NUM_WAYS-1:0]             valid_q, valid_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]             dirty_q, dirty_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][WAY_W-1:0]  age_q, age_d;
  logic [LINE_W-1:0] data_q [NUM_SETS][NUM_WAYS];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic [WORD_W-1:0]  word;
  logic               unused_byte_bits;

  assign idx              = addr_q[OFF_W +: INDEX_W];
  assign req_tag          = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign word             = addr_q[BYTE_W +: WORD_W];
  assign unused_byte_bits = ^addr_q[BYTE_W-1:0];

  logic             hit_any, inv_any;
  logic [WAY_W-1:0] hit_way, inv_way, lru_way, victim_sel;
  logic [NUM_WAYS-1:0][WAY_W-1:0] age_upd;
  logic [LINE_W-1:0] cur_line, merged_line;

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == req_tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  l2_lru_set #(
    .NUM_WAYS (NUM_WAYS),
    .AGE_W    (WAY_W)
  ) u_lru (
    .age_i     (age_q[idx]),
    .acc_way_i (hit_way),
    .age_o     (age_upd),
    .lru_way_o (lru_way)
  );

  assign victim_sel = inv_any ? inv_way : lru_way;
  assign cur_line   = data_q[idx][hit_way];

  always_comb begin
    merged_line = cur_line;
    merged_line[DATA_WIDTH*int'(word) +: DATA_WIDTH] = wdata_q;
  end

  logic              data_we;
  logic [WAY_W-1:0]  data_way;
  logic [LINE_W-1:0] data_line;

  always_comb begin
    state_d     = state_q;
    ready_en_d  = 1'b1;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    first_d     = first_q;
    fill_wait_d = fill_wait_q;
    victim_d    = victim_q;
    rdata_d     = rdata_q;
    hit_d       = hit_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    age_d       = age_q;
    data_we     = 1'b0;
    data_way    = hit_way;
    data_line   = merged_line;

    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready = ready_en_q;
        if (req_valid && ready_en_q) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          first_d = 1'b1;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (hit_any) begin
          rdata_d    = write_q ? '0 : cur_line[DATA_WIDTH*int'(word) +: DATA_WIDTH];
          hit_d      = first_q;
          age_d[idx] = age_upd;
          if (first_q && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
          if (write_q) begin
            data_we               = 1'b1;
            dirty_d[idx][hit_way] = 1'b1;
          end
          state_d = ST_RESPOND;
        end else begin
          if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
          first_d     = 1'b0;
          fill_wait_d = 1'b0;
          victim_d    = victim_sel;
          state_d     = (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel])
                        ? ST_WRITE_BACK : ST_ALLOCATE;
        end
      end
      ST_WRITE_BACK: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_q[idx][victim_q], idx, {OFF_W{1'b0}}};
        mem_req_wdata = data_q[idx][victim_q];
        if (mem_req_ready) begin
          dirty_d[idx][victim_q] = 1'b0;
          state_d                = ST_ALLOCATE;
        end
      end
      ST_ALLOCATE: begin
        if (!fill_wait_q) begin
          mem_req_valid = 1'b1;
          mem_req_addr  = {req_tag, idx, {OFF_W{1'b0}}};
          if (mem_req_ready) fill_wait_d = 1'b1;
        end else if (mem_resp_valid) begin
          // Install only; the re-run COMPARE hits and does LRU/write merge.
          data_we                = 1'b1;
          data_way               = victim_q;
          data_line              = mem_resp_rdata;
          valid_d[idx][victim_q] = 1'b1;
          dirty_d[idx][victim_q] = 1'b0;
          tag_d[idx][victim_q]   = req_tag;
          state_d                = ST_COMPARE;
        end
      end
      ST_RESPOND: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ready_en_q  <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      first_q     <= 1'b0;
      fill_wait_q <= 1'b0;
      victim_q    <= '0;
      rdata_q     <= '0;
      hit_q       <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      tag_q       <= '0;
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
    end else begin
      state_q     <= state_d;
      ready_en_q  <= ready_en_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      first_q     <= first_d;
      fill_wait_q <= fill_wait_d;
      victim_q    <= victim_d;
      rdata_q     <= rdata_d;
      hit_q       <= hit_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      tag_q       <= tag_d;
      age_q       <= age_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_q[idx][data_way] <= data_line;
  end

  assign resp_rdata = rdata_q;
  assign resp_hit   = hit_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_l2_cache_ctrl.sv
module tb_l2_cache_ctrl;
  import l2_cache_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_hit;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_req_addr;
  line_t       mem_req_wdata, mem_resp_rdata;
  logic        mem_resp_valid;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  l2_cache_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .WORDS_PER_LINE(4), .NUM_SETS(16), .NUM_WAYS(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // L3 model: untouched lines hold word i = line_address + i.
  line_t l3_mem [logic [31:0]];

  function automatic line_t l3_read(input logic [31:0] a);
    line_t l;
    if (l3_mem.exists(a)) return l3_mem[a];
    for (int i = 0; i < 4; i++) l[32*i +: 32] = a + 32'(i);
    return l;
  endfunction

  logic        t_got, t_hit;
  logic [31:0] t_rdata;
  int          t_lat, first_mem_cyc, proto_err;
  logic        log_wr[$];
  logic [31:0] log_addr[$];
  line_t       log_wdata[$];

  task automatic run_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input int hold);
    int cyc, hold_left;
    logic mv_seen, fill_next;
    logic [31:0] mv_addr, fill_addr;
    log_wr.delete(); log_addr.delete(); log_wdata.delete();
    t_got = 0; t_hit = 0; t_rdata = '0; t_lat = -1; first_mem_cyc = -1; proto_err = 0;
    cyc = 0; hold_left = hold; mv_seen = 0; fill_next = 0; mv_addr = '0; fill_addr = '0;
    @(negedge clk);
    chk("req_ready_idle", 128'(req_ready), 128'(1));
    req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    while (!t_got && cyc < 200) begin
      @(negedge clk); cyc++;
      if (fill_next && mem_req_valid) proto_err++;
      mem_resp_valid = 0; mem_resp_rdata = '0;
      if (fill_next) begin
        mem_resp_valid = 1; mem_resp_rdata = l3_read(fill_addr); fill_next = 0;
      end
      mem_req_ready = 0;
      if (req_ready) proto_err++;
      if (resp_valid) begin
        t_got = 1; t_rdata = resp_rdata; t_hit = resp_hit; t_lat = cyc;
      end
      if (mem_req_valid) begin
        if (first_mem_cyc < 0) first_mem_cyc = cyc;
        if (!mv_seen) begin mv_seen = 1; mv_addr = mem_req_addr; end
        else if (mem_req_addr !== mv_addr) proto_err++;
        if (hold_left > 0) hold_left--;
        else begin
          mem_req_ready = 1; mv_seen = 0;
          log_wr.push_back(mem_req_write);
          log_addr.push_back(mem_req_addr);
          log_wdata.push_back(mem_req_wdata);
          if (mem_req_write) l3_mem[mem_req_addr] = mem_req_wdata;
          else begin fill_next = 1; fill_addr = mem_req_addr; end
        end
      end else if (mv_seen) proto_err++;
    end
    mem_req_ready = 0; mem_resp_valid = 0;
    chk("resp_seen", 128'(t_got), 128'(1));
    chk("protocol", 128'(proto_err), 128'(0));
  endtask

  task automatic chk_mem(input int i, input logic wr, input logic [31:0] a);
    if (log_addr.size() > i) begin
      chk("mem_write_flag", 128'(log_wr[i]), 128'(wr));
      chk("mem_addr", 128'(log_addr[i]), 128'(a));
    end
  endtask

  initial begin
    line_t l;
    int cyc;
    reset_n = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    l3_mem[32'h100] = {32'h33, 32'h22, 32'h11, 32'h00};
    #2 reset_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_mem_req_valid", 128'(mem_req_valid), 128'(0));
    chk("rst_resp_valid", 128'(resp_valid), 128'(0));
    chk("rst_resp_rdata", 128'(resp_rdata), 128'(0));
    chk("rst_mem_req_addr", 128'(mem_req_addr), 128'(0));
    chk("rst_hit_count", 128'(hit_count), 128'(0));
    chk("rst_miss_count", 128'(miss_count), 128'(0));
    reset_n = 1;

    // Cold miss with clean fill.
    run_req(0, 32'h100, 0, 0);
    chk("cold_rdata", 128'(t_rdata), 128'(0));
    chk("cold_hit", 128'(t_hit), 128'(0));
    chk("cold_latency", 128'(t_lat), 128'(5));
    chk("cold_mem_req_cycle", 128'(first_mem_cyc), 128'(2));
    chk("cold_mem_count", 128'(log_addr.size()), 128'(1));
    chk_mem(0, 0, 32'h100);
    chk("cold_miss_count", 128'(miss_count), 128'(1));
    chk("cold_hit_count", 128'(hit_count), 128'(0));

    // Read hit.
    run_req(0, 32'h104, 0, 0);
    chk("hit_rdata", 128'(t_rdata), 128'(32'h11));
    chk("hit_flag", 128'(t_hit), 128'(1));
    chk("hit_latency", 128'(t_lat), 128'(2));
    chk("hit_mem_count", 128'(log_addr.size()), 128'(0));
    chk("hit_hit_count", 128'(hit_count), 128'(1));

    // Write hit makes way 0 dirty.
    run_req(1, 32'h108, 32'hDEADBEEF, 0);
    chk("whit_rdata", 128'(t_rdata), 128'(0));
    chk("whit_flag", 128'(t_hit), 128'(1));
    chk("whit_hit_count", 128'(hit_count), 128'(2));

    for (int k = 2; k <= 4; k++) begin
      run_req(0, 32'(k) << 8, 0, 0);
      chk("fill_rdata", 128'(t_rdata), 128'(32'(k) << 8));
      chk("fill_hit", 128'(t_hit), 128'(0));
      chk("fill_mem_count", 128'(log_addr.size()), 128'(1));
      chk_mem(0, 0, 32'(k) << 8);
    end
    chk("fill_miss_count", 128'(miss_count), 128'(4));

    // Set full; LRU way 0 (0x100) is dirty -> write-back, then fill.
    run_req(0, 32'h500, 0, 0);
    chk("wb_mem_count", 128'(log_addr.size()), 128'(2));
    chk_mem(0, 1, 32'h100);
    chk_mem(1, 0, 32'h500);
    if (log_wdata.size() > 0) begin
      l = log_wdata[0];
      chk("wb_word2", 128'(l[95:64]), 128'(32'hDEADBEEF));
      chk("wb_line", l, {32'h33, 32'hDEADBEEF, 32'h11, 32'h00});
    end
    chk("wb_rdata", 128'(t_rdata), 128'(32'h500));
    chk("wb_latency", 128'(t_lat), 128'(6));
    chk("wb_miss_count", 128'(miss_count), 128'(5));

    // Fill request held off by L3 for 10 cycles.
    run_req(0, 32'h600, 0, 10);
    chk("hold_latency", 128'(t_lat), 128'(15));
    chk("hold_mem_count", 128'(log_addr.size()), 128'(1));
    chk_mem(0, 0, 32'h600);
    chk("hold_rdata", 128'(t_rdata), 128'(32'h600));

    // Reset during ALLOCATE.
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = 32'h700;
    @(posedge clk); #1;
    req_valid = 0; req_addr = '0;
    cyc = 0;
    while (!mem_req_valid && cyc < 10) begin @(negedge clk); cyc++; end
    chk("rstmid_alloc", 128'(mem_req_valid), 128'(1));
    repeat (2) @(negedge clk);
    chk("rstmid_addr", 128'(mem_req_addr), 128'(32'h700));
    reset_n = 0; #1;
    chk("rstmid_mem_req_valid", 128'(mem_req_valid), 128'(0));
    chk("rstmid_mem_req_addr", 128'(mem_req_addr), 128'(0));
    chk("rstmid_req_ready", 128'(req_ready), 128'(0));
    chk("rstmid_resp_valid", 128'(resp_valid), 128'(0));
    chk("rstmid_miss_count", 128'(miss_count), 128'(0));
    chk("rstmid_hit_count", 128'(hit_count), 128'(0));
    repeat (2) @(negedge clk);
    reset_n = 1;

    run_req(0, 32'h100, 0, 0);
    chk("post_rst_hit", 128'(t_hit), 128'(0));
    chk("post_rst_miss_count", 128'(miss_count), 128'(1));
    chk("post_rst_hit_count", 128'(hit_count), 128'(0));
    for (int k = 2; k <= 4; k++) run_req(0, 32'(k) << 8, 0, 0);
    // Re-read 0x100 (word 2 carries the earlier written-back data).
    run_req(0, 32'h108, 0, 0);
    chk("reread_hit", 128'(t_hit), 128'(1));
    chk("reread_rdata", 128'(t_rdata), 128'(32'hDEADBEEF));
    run_req(0, 32'h500, 0, 0);
    chk("lru_mem_count", 128'(log_addr.size()), 128'(1));
    chk_mem(0, 0, 32'h500);
    run_req(0, 32'h100, 0, 0);
    chk("lru_keep_100", 128'(t_hit), 128'(1));
    run_req(0, 32'h200, 0, 0);
    chk("lru_evicted_200", 128'(t_hit), 128'(0));
    chk("final_hit_count", 128'(hit_count), 128'(2));
    chk("final_miss_count", 128'(miss_count), 128'(6));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
